// File: rtl/bp_pkg.sv
// Shared constants and the write-stage record for the branch-predictor updater.
package bp_pkg;

    // Record fields are sized for the widest supported configuration; the
    // updater uses only the low AWIDTH/DWIDTH bits and holds the rest at zero.
    localparam int unsigned BP_AW_MAX = 64;
    localparam int unsigned BP_DW_MAX = 16;

    // Weakly-taken allocation value: MSB set, all lower bits clear.
    function automatic int unsigned weak_t(input int unsigned dw);
        return 32'd1 << (dw - 1);
    endfunction

    // Weakly-not-taken allocation value: MSB clear, all lower bits set.
    function automatic int unsigned weak_nt(input int unsigned dw);
        return (32'd1 << (dw - 1)) - 32'd1;
    endfunction

    // Strongest taken value; the counter saturates here.
    function automatic int unsigned ctr_max(input int unsigned dw);
        return (32'd1 << dw) - 32'd1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [BP_AW_MAX-1:0] pc;
        logic [BP_DW_MAX-1:0] ctr;
    } s2_rec_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating-counter next-state: steps a hit counter toward the outcome,
// or allocates a weak value in the outcome's direction on a miss.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int DWIDTH = 2
) (
    input  logic              hit_i,
    input  logic [DWIDTH-1:0] ctr_i,
    input  logic              taken_i,
    output logic [DWIDTH-1:0] next_o
);

    localparam logic [DWIDTH-1:0] CTR_MAX = DWIDTH'(ctr_max(DWIDTH));
    localparam logic [DWIDTH-1:0] WEAK_T  = DWIDTH'(weak_t(DWIDTH));
    localparam logic [DWIDTH-1:0] WEAK_NT = DWIDTH'(weak_nt(DWIDTH));
    localparam logic [DWIDTH-1:0] CTR_ONE = {{(DWIDTH-1){1'b0}}, 1'b1};

    // Saturating increment/decrement on hit, weak allocation on miss.
    always_comb begin
        next_o = WEAK_NT;
        if (hit_i) begin
            if (taken_i) begin
                next_o = (ctr_i == CTR_MAX) ? ctr_i : ctr_i + CTR_ONE;
            end else begin
                next_o = (ctr_i == '0) ? ctr_i : ctr_i - CTR_ONE;
            end
        end else if (taken_i) begin
            next_o = WEAK_T;
        end
    end

endmodule

// File: rtl/bp_updater.sv
// Write-side controller for bp_cache: looks up the resolved branch on read
// port 1, computes the counter update, and issues the write one cycle later.
// A pending write to the same PC is forwarded so back-to-back updates never
// see the stale cache line. Also keeps branch / misprediction statistics.
module bp_updater
    import bp_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 2,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    input  logic [AWIDTH-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [AWIDTH-1:0] ra,
    input  logic [DWIDTH-1:0] rd_data,
    input  logic              rd_hit,
    output logic [AWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] din,
    output logic              we,
    output logic [CWIDTH-1:0] branch_cnt,
    output logic [CWIDTH-1:0] mispred_cnt
);

    s2_rec_t           s2_q, s2_d;
    logic [CWIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CWIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic              fwd_hit;
    logic              src_hit;
    logic [DWIDTH-1:0] src_ctr;
    logic [DWIDTH-1:0] next_ctr;
    logic              unused_s2;

    assign ra = upd_pc;

    // Counter source: pending S2 write first, then cache read port, else miss.
    always_comb begin
        fwd_hit = s2_q.valid && (s2_q.pc[AWIDTH-1:0] == upd_pc);
        src_hit = fwd_hit | rd_hit;
        src_ctr = fwd_hit ? s2_q.ctr[DWIDTH-1:0] : rd_data;
    end

    bp_sat_counter #(
        .DWIDTH (DWIDTH)
    ) u_sat (
        .hit_i   (src_hit),
        .ctr_i   (src_ctr),
        .taken_i (upd_taken),
        .next_o  (next_ctr)
    );

    // S2 next state: valid follows upd_valid; address/data hold when idle.
    always_comb begin
        s2_d       = s2_q;
        s2_d.valid = upd_valid;
        if (upd_valid) begin
            s2_d.pc               = '0;
            s2_d.pc[AWIDTH-1:0]   = upd_pc;
            s2_d.ctr              = '0;
            s2_d.ctr[DWIDTH-1:0]  = next_ctr;
        end
    end

    // Statistics: count accepted updates and direction mispredictions, wrapping.
    always_comb begin
        branch_cnt_d  = branch_cnt_q + CWIDTH'(upd_valid);
        mispred_cnt_d = mispred_cnt_q + CWIDTH'(upd_valid & (upd_pred ^ upd_taken));
    end

    // State registers; asynchronous reset drops any pending write at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_q          <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            s2_q          <= s2_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign we          = s2_q.valid;
    assign wa          = s2_q.pc[AWIDTH-1:0];
    assign din         = s2_q.ctr[DWIDTH-1:0];
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    // Upper record bits are held at zero and intentionally not consumed.
    assign unused_s2 = ^{s2_q.pc, s2_q.ctr};

endmodule

// File: tb/tb_bp_updater.sv
// Scoreboard bench for bp_updater with a small behavioural bp_cache model.
module tb_bp_updater;

    logic        clk;
    logic        reset;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic [31:0] ra;
    logic [1:0]  rd_data;
    logic        rd_hit;
    logic [31:0] wa;
    logic [1:0]  din;
    logic        we;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  din;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  model [logic [31:0]];
    int          n_cmp;
    int          n_fail;

    bp_updater #(
        .AWIDTH (32),
        .DWIDTH (2),
        .CWIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_pred    (upd_pred),
        .ra          (ra),
        .rd_data     (rd_data),
        .rd_hit      (rd_hit),
        .wa          (wa),
        .din         (din),
        .we          (we),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Cache model: commits the write port on the rising edge.
    always @(posedge clk) begin
        if (we) model[wa] = din;
    end

    // Monitor: every write the DUT presents is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got wa=0x%0h din=%b, expected no write", wa, din);
            end else begin
                e = exp_q.pop_front();
                check("wa", 64'(wa), 64'(e.pc));
                check("din", 64'(din), 64'(e.din));
            end
        end
    end

    // One update cycle: drive, optionally queue the expected write, step past the edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic t, input logic p,
                        input logic use_model, input logic h, input logic [1:0] d,
                        input logic push, input logic [1:0] exp_din);
        exp_t e;
        logic       hh;
        logic [1:0] dd;
        hh = h;
        dd = d;
        if (use_model) begin
            hh = model.exists(pc) ? 1'b1 : 1'b0;
            dd = hh ? model[pc] : 2'b00;
        end
        upd_valid = v;
        upd_pc    = pc;
        upd_taken = t;
        upd_pred  = p;
        rd_hit    = hh;
        rd_data   = dd;
        if (v && push) begin
            e.pc  = pc;
            e.din = exp_din;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Reset held with a valid update present: nothing may be written or counted.
        reset     = 1'b0;
        upd_valid = 1'b1;
        upd_pc    = 32'h08;
        upd_taken = 1'b1;
        upd_pred  = 1'b1;
        rd_hit    = 1'b0;
        rd_data   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 64'(we), 64'(0));
        check("rst_wa", 64'(wa), 64'(0));
        check("rst_din", 64'(din), 64'(0));
        check("rst_branch_cnt", 64'(branch_cnt), 64'(0));
        check("rst_mispred_cnt", 64'(mispred_cnt), 64'(0));

        // Release; first edge takes a miss-taken update to 0x08 -> weakly taken.
        reset = 1'b1;
        step(1'b1, 32'h08, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10);
        check("first_branch_cnt", 64'(branch_cnt), 64'(1));
        check("first_mispred_cnt", 64'(mispred_cnt), 64'(0));
        idle();

        // Hits read directly from the port (idle cycles keep forwarding out of it).
        step(1'b1, 32'h08, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 2'b10);
        check("hit_nt_mispred_cnt", 64'(mispred_cnt), 64'(1));
        idle();
        step(1'b1, 32'h08, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 2'b11);
        idle();
        step(1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00);
        idle();
        step(1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01);
        check("mid_branch_cnt", 64'(branch_cnt), 64'(5));
        check("mid_mispred_cnt", 64'(mispred_cnt), 64'(2));

        // Back-to-back 0x10 taken, cache reporting miss: forwarding gives 10, 11, 11.
        step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10);
        step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b11);
        step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b11);
        check("b2b_branch_cnt", 64'(branch_cnt), 64'(8));

        // Alternating PCs served by the cache model: no forwarding, values follow dout1.
        step(1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10);
        step(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10);
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01);
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01);
        step(1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10);
        check("alt_branch_cnt", 64'(branch_cnt), 64'(13));
        check("alt_mispred_cnt", 64'(mispred_cnt), 64'(4));

        // Asynchronous reset while a write is pending: it must vanish at once.
        step(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        check("pend_we", 64'(we), 64'(1));
        check("pend_wa", 64'(wa), 64'(32'h30));
        upd_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_we", 64'(we), 64'(0));
        check("async_branch_cnt", 64'(branch_cnt), 64'(0));
        check("async_mispred_cnt", 64'(mispred_cnt), 64'(0));
        @(posedge clk);
        #1;
        check("no_write_0x30", 64'(model.exists(32'h30)), 64'(0));
        reset = 1'b1;

        // Counting restarts cleanly after the second reset.
        step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10);
        check("post_branch_cnt", 64'(branch_cnt), 64'(1));
        check("post_mispred_cnt", 64'(mispred_cnt), 64'(1));
        idle();
        check("idle_we", 64'(we), 64'(0));
        check("idle_wa_hold", 64'(wa), 64'(32'h40));
        check("idle_din_hold", 64'(din), 64'(2'b10));
        idle();

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_updater.md
# bp_updater

Write-side controller for the two-read/one-write branch-predictor cache (`bp_cache`). Accepts one resolved branch per cycle from the execute stage and reads the current counter through the cache's second read port (`ra1`/`dout1`/`hit1`). Computes the saturating-counter update, allocates on miss, and drives the single write port (`wa`/`din`/`we`) one cycle later. Maintains branch and misprediction statistics for CSR readout; `ra0` stays with the fetch-stage predictor.

## Interface
- `AWIDTH`, 32: branch PC width; matches `bp_cache`.
- `DWIDTH`, 2: counter width, ≥2; MSB=1 means predict taken.
- `CWIDTH`, 32: statistics counter width.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `upd_valid`  in  1  resolved branch this cycle.
- `upd_pc`  in  AWIDTH  branch PC.
- `upd_taken`  in  1  actual outcome.
- `upd_pred`  in  1  direction predicted at fetch.
- `ra`  out  AWIDTH  to cache `ra1`; equals `upd_pc` combinationally.
- `rd_data`  in  DWIDTH  from cache `dout1`.
- `rd_hit`  in  1  from cache `hit1`.
- `wa`  out  AWIDTH  to cache `wa`.
- `din`  out  DWIDTH  to cache `din`.
- `we`  out  1  to cache `we`.
- `branch_cnt`  out  CWIDTH  resolved branches since reset.
- `mispred_cnt`  out  CWIDTH  mispredictions since reset.

## Operation
- Two stages: S1 (lookup+compute, combinational on inputs), S2 (registered write).
- S1 counter source, in priority order:
  - Forward: S2 valid and S2 pc == `upd_pc` → S2 `din`, treated as hit. Covers the cache not yet holding the pending write.
  - Else `rd_hit`=1 → `rd_data`.
  - Else miss.
- Next value:
  - Hit, taken: min(c+1, 2^DWIDTH−1).
  - Hit, not taken: max(c−1, 0).
  - Miss, taken: 2^(DWIDTH−1) (weakly taken).
  - Miss, not taken: 2^(DWIDTH−1)−1 (weakly not-taken).
- S2 register loads {valid=`upd_valid`, pc, next value} every cycle. The S2 valid bit drives `we`.
- `we` is asserted even when the value is unchanged (saturated): refreshes the line, keeping the allocation policy uniform.
- Stats on each accepted update:
  - `branch_cnt` += 1.
  - `mispred_cnt` += 1 if `upd_pred` != `upd_taken`.
  - Both wrap modulo 2^CWIDTH; no saturation.
- Always ready: no backpressure, no stall output. One update per cycle sustained.

## Timing
- Reset values: `we`=0, `wa`=0, `din`=0, S2 valid=0, `branch_cnt`=0, `mispred_cnt`=0.
- Reset assertion mid-operation drops any pending S2 write in the same instant (no write on the following edge).
- Latency: update sampled at edge E; `we`/`wa`/`din` valid during cycle E..E+1; cache holds the new value after edge E+1; fetch sees it via `ra0` from cycle after E+1.
- Stats update at edge E; visible in the cycle after E.
- Back-to-back same pc (cycles N, N+1): the N+1 update uses the forwarded value from N, never the stale cache value. Three consecutive taken updates to a miss line with DWIDTH=2 yield 10→11→11.
- Back-to-back different pc: no forwarding; each reads the cache directly.
- `upd_valid`=0: S2 valid=0 next cycle; `wa`/`din` hold last value; `we`=0.

## Structure
- Package `bp_pkg`:
  - `WEAK_T`/`WEAK_NT` constants as functions of DWIDTH.
  - `ctr_max` constant.
  - Typedef for the S2 record {valid, pc, ctr}.
- One sub-module `bp_sat_counter`: purely combinational (hit, ctr, taken) → next ctr, parameterized by DWIDTH.
- Forward mux, S2 register, and stat counters live in `bp_updater`.

## Test plan
- Reset with `upd_valid`=1 held → `we`=0, both counters 0; after release, first edge starts counting.
- Miss then taken, pc=0x08, `rd_hit`=0 → next cycle `we`=1, `wa`=0x08, `din`=2'b10; `branch_cnt`=1.
- Hit, pc=0x08, `rd_data`=2'b11, not taken, `upd_pred`=1 → `din`=2'b10; `mispred_cnt`=1. Hit 2'b11 taken → `din`=2'b11 (saturate). Hit 2'b00 not-taken → `din`=2'b00.
- Back-to-back pc=0x10 taken ×3 with cache model returning miss throughout → `din` sequence 10, 11, 11 via forwarding.
- Alternating pc 0x10/0x20 with cache model → no forwarding; `din` values follow the model's `dout1`.
- Async `reset` low mid-cycle while S2 valid → `we` drops before the next edge; cache model shows no write.
